thor2025_preg_freelist: RTL and testbench

THOR2025_PREG_FREELIST -- requirements
Module: thor2025_preg_freelist

---
 rtl/thor2025_preg_freelist_if.sv | 30 +++
 rtl/thor2025_preg_freelist.sv | 105 ++++++++++
 tb/tb_thor2025_preg_freelist.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/thor2025_preg_freelist_if.sv
// Rename-side handshake bundle for the physical register free list:
// allocation requests/grants, commit count, flush and RAT frees.
interface thor2025_preg_freelist_if;
    logic [1:0] alloc_req;
    logic       alloc_ack;
    logic [6:0] alloc_preg0;
    logic [6:0] alloc_preg1;
    logic [1:0] cmt_n;
    logic       flush;
    logic [2:0] free_v;
    logic [6:0] free_preg0;
    logic [6:0] free_preg1;
    logic [6:0] free_preg2;
    logic [7:0] free_cnt;
    logic       ovf_err;

    modport master (
        output alloc_req, cmt_n, flush,
        output free_v, free_preg0, free_preg1, free_preg2,
        input  alloc_ack, alloc_preg0, alloc_preg1,
        input  free_cnt, ovf_err
    );

    modport slave (
        input  alloc_req, cmt_n, flush,
        input  free_v, free_preg0, free_preg1, free_preg2,
        output alloc_ack, alloc_preg0, alloc_preg1,
        output free_cnt, ovf_err
    );
endinterface

// File: rtl/thor2025_preg_freelist.sv
// Circular free list of physical register tags with speculative
// allocation (head), commit (cmt_head) and release (tail) pointers.
module thor2025_preg_freelist #(
    parameter int NPREG = 128
) (
    input  logic clk,
    input  logic rst,
    thor2025_preg_freelist_if.slave fl
);
    localparam int PW = $clog2(NPREG);
    typedef logic [PW-1:0] ptr_t;

    logic [6:0] r_buf [NPREG];
    ptr_t       r_head;
    ptr_t       r_cmt;
    ptr_t       r_tail;
    logic [7:0] r_free_cnt;
    logic       r_ovf;

    logic [1:0] w_want;
    logic       w_ack;
    ptr_t       w_outst;
    logic       w_under;
    ptr_t       w_cmt_nx;
    ptr_t       w_room;
    logic [6:0] w_tag [3];
    logic [2:0] w_fv;
    logic [2:0] w_wr;
    ptr_t       w_off [3];
    ptr_t       w_nwr;
    logic       w_drop;
    ptr_t       w_head_nx;
    ptr_t       w_tail_nx;

    assign w_want = 2'(fl.alloc_req[0]) + 2'(fl.alloc_req[1]);
    assign w_ack  = (w_want != 2'd0)
                 && (r_free_cnt >= {6'd0, w_want})
                 && !fl.flush && !rst;

    assign fl.alloc_ack   = w_ack;
    assign fl.alloc_preg0 = r_buf[r_head];
    assign fl.alloc_preg1 = (fl.alloc_req == 2'b10) ? r_buf[r_head]
                                                    : r_buf[r_head + ptr_t'(1)];
    assign fl.free_cnt    = r_free_cnt;
    assign fl.ovf_err     = r_ovf;

    assign w_tag[0] = fl.free_preg0;
    assign w_tag[1] = fl.free_preg1;
    assign w_tag[2] = fl.free_preg2;

    always_comb begin
        w_outst   = r_head - r_cmt;
        w_under   = ptr_t'(fl.cmt_n) > w_outst;
        // An underflowing commit is clamped so cmt_head never passes head
        w_cmt_nx  = r_cmt + (w_under ? w_outst : ptr_t'(fl.cmt_n));
        w_room    = ptr_t'(NPREG - 1) - (r_tail - w_cmt_nx);
        w_fv      = '0;
        w_wr      = '0;
        w_nwr     = '0;
        w_off[0]  = '0;
        w_off[1]  = '0;
        w_off[2]  = '0;
        for (int k = 0; k < 3; k++) begin
            w_fv[k] = fl.free_v[k] && (w_tag[k] != 7'd0);
        end
        w_off[1] = ptr_t'(w_fv[0]);
        w_off[2] = w_off[1] + ptr_t'(w_fv[1]);
        for (int k = 0; k < 3; k++) begin
            w_wr[k] = w_fv[k] && (w_off[k] < w_room);
            w_nwr   = w_nwr + ptr_t'(w_wr[k]);
        end
        w_drop    = |(w_fv & ~w_wr);
        w_tail_nx = r_tail + w_nwr;
        w_head_nx = r_head;
        if (fl.flush) begin
            w_head_nx = w_cmt_nx;
        end else if (w_ack) begin
            w_head_nx = r_head + ptr_t'(w_want);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPREG; i++) begin
                r_buf[i] <= (i < NPREG - 1) ? 7'(i + 1) : 7'd0;
            end
            r_head     <= '0;
            r_cmt      <= '0;
            r_tail     <= ptr_t'(NPREG - 1);
            r_free_cnt <= 8'(NPREG - 1);
            r_ovf      <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_wr[k]) begin
                    r_buf[r_tail + w_off[k]] <= w_tag[k];
                end
            end
            r_head     <= w_head_nx;
            r_cmt      <= w_cmt_nx;
            r_tail     <= w_tail_nx;
            r_free_cnt <= 8'(ptr_t'(w_tail_nx - w_head_nx));
            r_ovf      <= r_ovf | w_under | w_drop;
        end
    end
endmodule

// File: tb/tb_thor2025_preg_freelist.sv
// Directed bench for the physical register free list: reset, grants,
// flush recovery, tag-0 filtering, no-bypass frees and error flag.
module tb_thor2025_preg_freelist;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    thor2025_preg_freelist_if fl_if ();

    thor2025_preg_freelist #(.NPREG(128)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] cn,
                         input logic fls, input logic [2:0] fv,
                         input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c);
        fl_if.alloc_req  = req;
        fl_if.cmt_n      = cn;
        fl_if.flush      = fls;
        fl_if.free_v     = fv;
        fl_if.free_preg0 = a;
        fl_if.free_preg1 = b;
        fl_if.free_preg2 = c;
    endtask

    task automatic idle();
        drive(2'b00, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle();
        tick();

        // Everything is ignored while reset is held
        drive(2'b11, 2'd2, 1'b1, 3'b111, 7'd5, 7'd6, 7'd7);
        #1;
        chk("rst_ack", 32'(fl_if.alloc_ack), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        chk("rst_cnt", 32'(fl_if.free_cnt), 32'd127);
        chk("rst_ovf", 32'(fl_if.ovf_err), 32'd0);

        // Dual grant from reset
        drive(2'b11, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        #1;
        chk("a11_ack", 32'(fl_if.alloc_ack), 32'd1);
        chk("a11_p0", 32'(fl_if.alloc_preg0), 32'd1);
        chk("a11_p1", 32'(fl_if.alloc_preg1), 32'd2);
        tick();
        chk("a11_cnt", 32'(fl_if.free_cnt), 32'd125);

        // Flush rewinds to the post-commit point
        drive(2'b11, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        #1;
        chk("a2_p0", 32'(fl_if.alloc_preg0), 32'd3);
        tick();
        drive(2'b00, 2'd1, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        tick();
        drive(2'b01, 2'd0, 1'b1, 3'b000, 7'd0, 7'd0, 7'd0);
        #1;
        chk("fl_ack", 32'(fl_if.alloc_ack), 32'd0);
        tick();
        chk("fl_cnt", 32'(fl_if.free_cnt), 32'd126);
        drive(2'b01, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        #1;
        chk("fl_ack2", 32'(fl_if.alloc_ack), 32'd1);
        chk("fl_tag", 32'(fl_if.alloc_preg0), 32'd2);
        tick();
        chk("fl_cnt2", 32'(fl_if.free_cnt), 32'd125);

        // Tag 0 dropped; 40,41 appended
        drive(2'b00, 2'd1, 1'b0, 3'b111, 7'd0, 7'd40, 7'd41);
        tick();
        idle();
        chk("fr_cnt", 32'(fl_if.free_cnt), 32'd127);
        chk("fr_ovf", 32'(fl_if.ovf_err), 32'd0);

        // Mid-run reset discards outstanding state
        rst = 1'b1;
        drive(2'b11, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        tick();
        rst = 1'b0;
        idle();
        chk("rst2_cnt", 32'(fl_if.free_cnt), 32'd127);

        // Drain to one free tag
        drive(2'b11, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        for (int i = 0; i < 63; i++) tick();
        chk("drain_cnt", 32'(fl_if.free_cnt), 32'd1);
        #1;
        chk("short_ack", 32'(fl_if.alloc_ack), 32'd0);
        tick();
        chk("short_cnt", 32'(fl_if.free_cnt), 32'd1);
        drive(2'b10, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        #1;
        chk("b_ack", 32'(fl_if.alloc_ack), 32'd1);
        chk("b_p1", 32'(fl_if.alloc_preg1), 32'd127);
        tick();
        chk("b_cnt", 32'(fl_if.free_cnt), 32'd0);

        // Free at empty is not bypassed to a same-cycle request
        drive(2'b01, 2'd1, 1'b0, 3'b001, 7'd77, 7'd0, 7'd0);
        #1;
        chk("nb_ack", 32'(fl_if.alloc_ack), 32'd0);
        tick();
        chk("nb_cnt", 32'(fl_if.free_cnt), 32'd1);
        drive(2'b01, 2'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        #1;
        chk("nb_ack2", 32'(fl_if.alloc_ack), 32'd1);
        chk("nb_tag", 32'(fl_if.alloc_preg0), 32'd77);
        tick();
        chk("nb_cnt2", 32'(fl_if.free_cnt), 32'd0);
        chk("nb_ovf", 32'(fl_if.ovf_err), 32'd0);

        // Free with no room is dropped and flagged
        drive(2'b00, 2'd0, 1'b0, 3'b001, 7'd50, 7'd0, 7'd0);
        tick();
        idle();
        chk("of_ovf", 32'(fl_if.ovf_err), 32'd1);
        chk("of_cnt", 32'(fl_if.free_cnt), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clr_ovf", 32'(fl_if.ovf_err), 32'd0);

        // Commit underflow is sticky until reset
        drive(2'b00, 2'd2, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
        tick();
        idle();
        chk("uf_ovf", 32'(fl_if.ovf_err), 32'd1);
        tick();
        tick();
        tick();
        chk("uf_stk", 32'(fl_if.ovf_err), 32'd1);
        chk("uf_cnt", 32'(fl_if.free_cnt), 32'd127);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("uf_clr", 32'(fl_if.ovf_err), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
